// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the debug/control unit (master) and pc_sequencer (slave).
// Carries run/step/clear control, hazard and redirect inputs, and PC/advance status back.
interface pc_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_start;
    logic                  i_step_mode;
    logic                  i_step;
    logic                  i_clear;
    logic                  i_stall;
    logic                  i_jump;
    logic [DATA_WIDTH-1:0] i_jump_target;
    logic                  i_branch_taken;
    logic [DATA_WIDTH-1:0] i_branch_target;
    logic                  i_halt;
    logic [DATA_WIDTH-1:0] o_pc;
    logic [DATA_WIDTH-1:0] o_pc_incr;
    logic                  o_advance;
    logic                  o_halted;
    logic [31:0]           o_cycle_count;

    modport master (
        output i_start, i_step_mode, i_step, i_clear, i_stall,
               i_jump, i_jump_target, i_branch_taken, i_branch_target, i_halt,
        input  o_pc, o_pc_incr, o_advance, o_halted, o_cycle_count
    );

    modport slave (
        input  i_start, i_step_mode, i_step, i_clear, i_stall,
               i_jump, i_jump_target, i_branch_taken, i_branch_target, i_halt,
        output o_pc, o_pc_incr, o_advance, o_halted, o_cycle_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC register + run/step/halt control for fetch; optional advance counter under PC_SEQ_CYCLE_COUNT_EN.
// Latency: new PC one edge after inputs sampled; o_advance/o_pc_incr are combinational.
// Backpressure: i_stall holds the PC and drops o_advance unless a taken branch redirects.
module pc_sequencer #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    pc_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP_WAIT,
        S_STEP_EXEC,
        S_HALTED
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_incr;
    logic                  halted;
    logic                  active;
    logic                  advance;

    assign active  = (state == S_RUN) || (state == S_STEP_EXEC);
    assign pc_incr = pc + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    // A taken branch resolves in EX and must flush/redirect even while ID is stalled.
    assign advance = active && (!bus.i_stall || bus.i_branch_taken);

    assign bus.o_pc      = pc;
    assign bus.o_pc_incr = pc_incr;
    assign bus.o_advance = advance;
    assign bus.o_halted  = halted;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            halted <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_start)
                        state <= bus.i_step_mode ? S_STEP_WAIT : S_RUN;
                end
                S_STEP_WAIT: begin
                    if (bus.i_step)
                        state <= S_STEP_EXEC;
                end
                S_RUN, S_STEP_EXEC: begin
                    // A step is consumed even when it stalls; the next pulse retries.
                    if (state == S_STEP_EXEC)
                        state <= S_STEP_WAIT;
                    if (bus.i_branch_taken) begin
                        pc <= bus.i_branch_target;
                    end else if (bus.i_stall) begin
                        pc <= pc;
                    end else if (bus.i_jump) begin
                        pc <= bus.i_jump_target;
                    end else if (bus.i_halt) begin
                        state  <= S_HALTED;
                        halted <= 1'b1;
                    end else begin
                        pc <= pc_incr;
                    end
                end
                S_HALTED: begin
                    if (bus.i_clear) begin
                        state  <= S_IDLE;
                        pc     <= RESET_PC;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_SEQ_CYCLE_COUNT_EN
    logic [31:0] cycle_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            cycle_count <= '0;
        else if (state == S_HALTED && bus.i_clear)
            cycle_count <= '0;
        else if (advance)
            cycle_count <= cycle_count + 32'd1;
    end

    assign bus.o_cycle_count = cycle_count;
`else
    assign bus.o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then random stimulus,
// all outputs compared every cycle against a flag-based behavioural model.
module tb_pc_sequencer;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    pc_sequencer_if #(.DATA_WIDTH(32)) bus ();

    pc_sequencer #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a handful of flags describing the machine's situation.
    bit          m_started;
    bit          m_stepmode;
    bit          m_exec;
    bit          m_halt;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_adv_now;

    function automatic bit m_active();
        return m_started && !m_halt && (!m_stepmode || m_exec);
    endfunction

    function automatic bit m_adv();
        return m_active() && (!bus.i_stall || bus.i_branch_taken);
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_started  = 1'b0;
            m_stepmode = 1'b0;
            m_exec     = 1'b0;
            m_halt     = 1'b0;
            m_pc       = 32'h0;
            m_cnt      = 32'h0;
        end else begin
            m_adv_now = m_adv();
            if (m_adv_now) m_cnt = m_cnt + 32'd1;
            if (!m_started) begin
                if (bus.i_start) begin
                    m_started  = 1'b1;
                    m_stepmode = bus.i_step_mode;
                    m_exec     = 1'b0;
                end
            end else if (m_halt) begin
                if (bus.i_clear) begin
                    m_halt    = 1'b0;
                    m_started = 1'b0;
                    m_pc      = 32'h0;
                    m_cnt     = 32'h0;
                end
            end else if (!m_active()) begin
                if (bus.i_step) m_exec = 1'b1;
            end else begin
                m_exec = 1'b0;
                if (bus.i_branch_taken)  m_pc = bus.i_branch_target;
                else if (bus.i_stall)    m_pc = m_pc;
                else if (bus.i_jump)     m_pc = bus.i_jump_target;
                else if (bus.i_halt)     m_halt = 1'b1;
                else                     m_pc = m_pc + 32'd1;
            end
        end
    end

    function automatic logic [31:0] exp_cnt();
`ifdef PC_SEQ_CYCLE_COUNT_EN
        return m_cnt;
`else
        return 32'h0;
`endif
    endfunction

    always @(negedge i_clk) begin
        if (cmp_en) begin
            chk("model.o_pc",          bus.o_pc,                 m_pc);
            chk("model.o_pc_incr",     bus.o_pc_incr,            m_pc + 32'd1);
            chk("model.o_advance",     {31'd0, bus.o_advance},   {31'd0, m_adv()});
            chk("model.o_halted",      {31'd0, bus.o_halted},    {31'd0, m_halt});
            chk("model.o_cycle_count", bus.o_cycle_count,        exp_cnt());
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic quiet();
        bus.i_start         = 1'b0;
        bus.i_step_mode     = 1'b0;
        bus.i_step          = 1'b0;
        bus.i_clear         = 1'b0;
        bus.i_stall         = 1'b0;
        bus.i_jump          = 1'b0;
        bus.i_jump_target   = 32'h0;
        bus.i_branch_taken  = 1'b0;
        bus.i_branch_target = 32'h0;
        bus.i_halt          = 1'b0;
    endtask

    task automatic jump_to(input logic [31:0] t);
        bus.i_jump = 1'b1; bus.i_jump_target = t;
        cyc();
        bus.i_jump = 1'b0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        quiet();
        cyc();
        i_rst_n = 1'b1;
    endtask

    initial begin
        quiet();
        cmp_en = 1'b1;
        cyc();
        chk("rst.pc",      bus.o_pc,                0);
        chk("rst.halted",  {31'd0, bus.o_halted},   0);
        chk("rst.advance", {31'd0, bus.o_advance},  0);
        chk("rst.count",   bus.o_cycle_count,       0);
        i_rst_n = 1'b1;
        cyc();

        // Free run from reset
        bus.i_start = 1'b1;
        cyc();
        bus.i_start = 1'b0;
        chk("run.pc0",  bus.o_pc, 0);
        chk("run.adv0", {31'd0, bus.o_advance}, 1);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk("run.pcN", bus.o_pc, i);
        end

        // Stall two cycles at PC=5 then jump
        bus.i_stall = 1'b1;
        #1 chk("stall.adv", {31'd0, bus.o_advance}, 0);
        cyc(); chk("stall.pc1", bus.o_pc, 5);
        cyc(); chk("stall.pc2", bus.o_pc, 5);
        bus.i_stall = 1'b0;
        jump_to(32'h40);
        chk("jump.pc", bus.o_pc, 32'h40);

        // Branch beats stall and jump
        jump_to(32'd10);
        chk("pre_br.pc", bus.o_pc, 10);
        bus.i_jump = 1'b1; bus.i_jump_target = 32'h20;
        bus.i_branch_taken = 1'b1; bus.i_branch_target = 32'h80;
        bus.i_stall = 1'b1;
        #1 chk("br.adv", {31'd0, bus.o_advance}, 1);
        cyc();
        quiet();
        chk("br.pc", bus.o_pc, 32'h80);

        // Halt at PC=7, start ignored, clear returns to idle
        jump_to(32'd7);
        bus.i_halt = 1'b1;
        cyc();
        bus.i_halt = 1'b0;
        chk("halt.flag", {31'd0, bus.o_halted}, 1);
        bus.i_start = 1'b1;
        repeat (10) cyc();
        bus.i_start = 1'b0;
        chk("halt.pc",  bus.o_pc, 7);
        chk("halt.adv", {31'd0, bus.o_advance}, 0);
        bus.i_clear = 1'b1;
        cyc();
        bus.i_clear = 1'b0;
        chk("clear.pc",     bus.o_pc, 0);
        chk("clear.halted", {31'd0, bus.o_halted}, 0);
        chk("clear.count",  bus.o_cycle_count, 0);

        // Single-step
        bus.i_start = 1'b1; bus.i_step_mode = 1'b1;
        cyc();
        bus.i_start = 1'b0; bus.i_step_mode = 1'b0;
        repeat (5) cyc();
        chk("step.idle_pc",  bus.o_pc, 0);
        chk("step.idle_adv", {31'd0, bus.o_advance}, 0);
        for (int s = 1; s <= 2; s++) begin
            bus.i_step = 1'b1;
            cyc();
            bus.i_step = 1'b0;
            chk("step.exec_adv", {31'd0, bus.o_advance}, 1);
            cyc();
            chk("step.pc", bus.o_pc, s);
            chk("step.wait_adv", {31'd0, bus.o_advance}, 0);
        end
`ifdef PC_SEQ_CYCLE_COUNT_EN
        chk("step.count", bus.o_cycle_count, 2);
`else
        chk("step.count", bus.o_cycle_count, 0);
`endif

        // Wrap at all-ones
        do_reset();
        bus.i_start = 1'b1;
        cyc();
        bus.i_start = 1'b0;
        jump_to(32'hFFFF_FFFF);
        chk("wrap.pc",   bus.o_pc,      32'hFFFF_FFFF);
        chk("wrap.incr", bus.o_pc_incr, 32'h0);
        cyc();
        chk("wrap.next", bus.o_pc, 32'h0);

        // Asynchronous reset mid-run
        repeat (3) cyc();
        #3 i_rst_n = 1'b0;
        #1 chk("arst.pc", bus.o_pc, 0);
        chk("arst.halted", {31'd0, bus.o_halted}, 0);
        cyc();
        i_rst_n = 1'b1;

        // Randomised traffic
        for (int n = 0; n < 4000; n++) begin
            bus.i_start         = ($urandom_range(0, 99) < 30);
            bus.i_step_mode     = $urandom_range(0, 1) == 1;
            bus.i_step          = ($urandom_range(0, 99) < 30);
            bus.i_clear         = ($urandom_range(0, 99) < 20);
            bus.i_stall         = ($urandom_range(0, 99) < 20);
            bus.i_jump          = ($urandom_range(0, 99) < 10);
            bus.i_jump_target   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
            bus.i_branch_taken  = ($urandom_range(0, 99) < 8);
            bus.i_branch_target = $urandom;
            bus.i_halt          = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 499) == 0) begin
                #3 i_rst_n = 1'b0;
                #1 chk("rnd.arst_pc", bus.o_pc, 0);
                #2 i_rst_n = 1'b1;
            end
            cyc();
        end

        quiet();
        cyc();
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
